// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: opcodes, FSM states,
// mux selects and trap causes, plus the opcode classifier used by the FSM.
package multicycle_ctrl_pkg;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_L    = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_I, C_L, C_S, C_B, C_JAL, C_JALR, C_BAD
  } op_class_t;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JAL    = 2'b10;
  localparam logic [1:0] PC_JALR   = 2'b11;

  localparam logic [1:0] M2R_ALU   = 2'b00;
  localparam logic [1:0] M2R_MEM   = 2'b01;
  localparam logic [1:0] M2R_JAL   = 2'b10;
  localparam logic [1:0] M2R_JALR  = 2'b11;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  function automatic op_class_t classify(input logic [6:0] op);
    case (op)
      OP_R:    return C_R;
      OP_I:    return C_I;
      OP_L:    return C_L;
      OP_S:    return C_S;
      OP_B:    return C_B;
      OP_JAL:  return C_JAL;
      OP_JALR: return C_JALR;
      default: return C_BAD;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory-wait cycles; expired flags the cycle that is the
// MEM_TIMEOUT-th wait. MEM_TIMEOUT = 0 disables the timeout entirely.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic waiting,
  output logic expired
);

  localparam int W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam bit ENABLED = (MEM_TIMEOUT > 0);
  localparam logic [W-1:0] LAST = W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_count <= '0;
    end else if (waiting && (r_count != LAST)) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Counter holds the number of waits already completed, so LAST marks the final one.
  assign expired = ENABLED && waiting && (r_count == LAST);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB over one shared
// memory port, with illegal-opcode and memory-timeout trapping.
module multicycle_control
  import multicycle_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT  = 15,
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_instr,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       alu_src,
  output logic       reg_write,
  output logic [1:0] mem_to_reg,
  output logic       instr_done,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [2:0] state
);

  // Memory handshake: mem_req is held (with mem_we/mem_instr stable) until the
  // cycle mem_ready is high; that cycle completes the request. mem_ready seen
  // while mem_req is low has no effect.

  state_t    r_state, w_next;
  logic [6:0] r_op_q;
  logic [1:0] r_trap_cause, w_next_cause;
  op_class_t w_dec_class, w_q_class;
  logic      w_waiting, w_expired, w_clear;

  assign w_dec_class = classify(opcode);
  assign w_q_class   = classify(r_op_q);
  assign w_waiting   = ((r_state == S_FETCH) || (r_state == S_MEM)) && !mem_ready;
  assign w_clear     = (w_next != r_state);

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_clear),
    .waiting (w_waiting),
    .expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_FETCH;
      r_op_q       <= '0;
      r_trap_cause <= CAUSE_NONE;
    end else begin
      r_state      <= w_next;
      r_trap_cause <= w_next_cause;
      if (r_state == S_DECODE) r_op_q <= opcode;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_next_cause = r_trap_cause;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_instr    = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PC_PLUS4;
    alu_src      = 1'b0;
    reg_write    = 1'b0;
    mem_to_reg   = M2R_ALU;
    instr_done   = 1'b0;

    case (r_state)
      S_FETCH: begin
        mem_req   = 1'b1;
        mem_instr = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          w_next   = S_DECODE;
        end else if (w_expired) begin
          w_next       = S_TRAP;
          w_next_cause = CAUSE_TIMEOUT;
        end
      end

      S_DECODE: begin
        if (w_dec_class == C_BAD) begin
          if (ILLEGAL_TRAP) begin
            w_next       = S_TRAP;
            w_next_cause = CAUSE_ILLEGAL;
          end else begin
            instr_done = 1'b1;
            w_next     = S_FETCH;
          end
        end else begin
          w_next = S_EXEC;
        end
      end

      S_EXEC: begin
        case (w_q_class)
          C_R: w_next = S_WB;
          C_I: begin
            alu_src = 1'b1;
            w_next  = S_WB;
          end
          C_L, C_S: begin
            alu_src = 1'b1;
            w_next  = S_MEM;
          end
          C_B: begin
            pc_write   = branch_taken;
            pc_src     = PC_BRANCH;
            instr_done = 1'b1;
            w_next     = S_FETCH;
          end
          C_JAL: begin
            pc_write = 1'b1;
            pc_src   = PC_JAL;
            w_next   = S_WB;
          end
          C_JALR: begin
            alu_src  = 1'b1;
            pc_write = 1'b1;
            pc_src   = PC_JALR;
            w_next   = S_WB;
          end
          default: w_next = S_FETCH;
        endcase
      end

      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (w_q_class == C_S);
        if (mem_ready) begin
          if (w_q_class == C_S) begin
            instr_done = 1'b1;
            w_next     = S_FETCH;
          end else begin
            w_next = S_WB;
          end
        end else if (w_expired) begin
          w_next       = S_TRAP;
          w_next_cause = CAUSE_TIMEOUT;
        end
      end

      S_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
        case (w_q_class)
          C_L:     mem_to_reg = M2R_MEM;
          C_JAL:   mem_to_reg = M2R_JAL;
          C_JALR:  mem_to_reg = M2R_JALR;
          default: mem_to_reg = M2R_ALU;
        endcase
      end

      S_TRAP: w_next = S_TRAP;

      default: w_next = S_FETCH;
    endcase
  end

  assign trap       = (r_state == S_TRAP);
  assign trap_cause = r_trap_cause;
  assign state      = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: three parameterisations share one stimulus bus;
// each cycle the expected output vector is queued and compared after drive.
module tb_multicycle_control;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_L    = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BAD  = 7'b1111111;

  localparam int D_DEF = 0;  // MEM_TIMEOUT 15, ILLEGAL_TRAP 1
  localparam int D_NOP = 1;  // ILLEGAL_TRAP 0
  localparam int D_T4  = 2;  // MEM_TIMEOUT 4

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] opcode = '0;
  logic       branch_taken = 1'b0;
  logic       mem_ready = 1'b0;

  logic       mem_req_w [3];
  logic       mem_we_w [3];
  logic       mem_instr_w [3];
  logic       ir_write_w [3];
  logic       pc_write_w [3];
  logic [1:0] pc_src_w [3];
  logic       alu_src_w [3];
  logic       reg_write_w [3];
  logic [1:0] mem_to_reg_w [3];
  logic       instr_done_w [3];
  logic       trap_w [3];
  logic [1:0] trap_cause_w [3];
  logic [2:0] state_w [3];
  logic [17:0] obs [3];

  logic [17:0] exp_q[$];
  string       tag_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  multicycle_control #(.MEM_TIMEOUT(15), .ILLEGAL_TRAP(1'b1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(mem_req_w[0]), .mem_we(mem_we_w[0]), .mem_instr(mem_instr_w[0]),
    .ir_write(ir_write_w[0]), .pc_write(pc_write_w[0]), .pc_src(pc_src_w[0]),
    .alu_src(alu_src_w[0]), .reg_write(reg_write_w[0]), .mem_to_reg(mem_to_reg_w[0]),
    .instr_done(instr_done_w[0]), .trap(trap_w[0]), .trap_cause(trap_cause_w[0]),
    .state(state_w[0])
  );

  multicycle_control #(.MEM_TIMEOUT(15), .ILLEGAL_TRAP(1'b0)) dut_nop (
    .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(mem_req_w[1]), .mem_we(mem_we_w[1]), .mem_instr(mem_instr_w[1]),
    .ir_write(ir_write_w[1]), .pc_write(pc_write_w[1]), .pc_src(pc_src_w[1]),
    .alu_src(alu_src_w[1]), .reg_write(reg_write_w[1]), .mem_to_reg(mem_to_reg_w[1]),
    .instr_done(instr_done_w[1]), .trap(trap_w[1]), .trap_cause(trap_cause_w[1]),
    .state(state_w[1])
  );

  multicycle_control #(.MEM_TIMEOUT(4), .ILLEGAL_TRAP(1'b1)) dut_t4 (
    .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(mem_req_w[2]), .mem_we(mem_we_w[2]), .mem_instr(mem_instr_w[2]),
    .ir_write(ir_write_w[2]), .pc_write(pc_write_w[2]), .pc_src(pc_src_w[2]),
    .alu_src(alu_src_w[2]), .reg_write(reg_write_w[2]), .mem_to_reg(mem_to_reg_w[2]),
    .instr_done(instr_done_w[2]), .trap(trap_w[2]), .trap_cause(trap_cause_w[2]),
    .state(state_w[2])
  );

  for (genvar k = 0; k < 3; k++) begin : g_obs
    assign obs[k] = {state_w[k], mem_req_w[k], mem_we_w[k], mem_instr_w[k], ir_write_w[k],
                     pc_write_w[k], pc_src_w[k], alu_src_w[k], reg_write_w[k],
                     mem_to_reg_w[k], instr_done_w[k], trap_w[k], trap_cause_w[k]};
  end

  // Vector layout: state,req,we,instr,irw,pcw,pc_src,alu_src,rw,m2r,done,trap,cause
  function automatic logic [17:0] ev(input logic [2:0] st, input logic req, input logic we,
                                     input logic mi, input logic irw, input logic pcw,
                                     input logic [1:0] ps, input logic as, input logic rw,
                                     input logic [1:0] m2r, input logic dn, input logic tr,
                                     input logic [1:0] tc);
    return {st, req, we, mi, irw, pcw, ps, as, rw, m2r, dn, tr, tc};
  endfunction

  function automatic logic [17:0] e_fetch(input logic rdy);
    return ev(3'd0, 1'b1, 1'b0, 1'b1, rdy, rdy, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00);
  endfunction
  function automatic logic [17:0] e_dec(input logic dn);
    return ev(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, dn, 1'b0, 2'b00);
  endfunction
  function automatic logic [17:0] e_exec(input logic as, input logic pcw, input logic [1:0] ps,
                                         input logic dn);
    return ev(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, pcw, ps, as, 1'b0, 2'b00, dn, 1'b0, 2'b00);
  endfunction
  function automatic logic [17:0] e_mem(input logic we, input logic dn);
    return ev(3'd3, 1'b1, we, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, dn, 1'b0, 2'b00);
  endfunction
  function automatic logic [17:0] e_wb(input logic [1:0] m2r);
    return ev(3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, m2r, 1'b1, 1'b0, 2'b00);
  endfunction
  function automatic logic [17:0] e_trap(input logic [1:0] tc);
    return ev(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, tc);
  endfunction

  task automatic check_eq(input string tag, input logic [17:0] got, input logic [17:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (st,req,we,mi,irw,pcw,ps,as,rw,m2r,dn,tr,tc)",
               tag, got, exp);
    end
  endtask

  // Hold rst for one rising edge; the next cyc call releases it.
  task automatic do_reset(input logic [6:0] op);
    @(negedge clk);
    rst = 1'b1;
    mem_ready = 1'b0;
    branch_taken = 1'b0;
    opcode = op;
  endtask

  task automatic cyc(input int sel, input logic rdy, input logic bt, input logic [17:0] exp,
                     input string tag);
    logic [17:0] got;
    @(negedge clk);
    rst = 1'b0;
    mem_ready = rdy;
    branch_taken = bt;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    #1;
    got = obs[sel];
    check_eq(tag_q.pop_front(), got, exp_q.pop_front());
  endtask

  logic [6:0] op_tab [4]  = '{OP_R, OP_I, OP_JAL, OP_JALR};
  logic       as_tab [4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic       pcw_tab [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic [1:0] ps_tab [4]  = '{2'b00, 2'b00, 2'b10, 2'b11};
  logic [1:0] m2r_tab [4] = '{2'b00, 2'b00, 2'b10, 2'b11};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and a zero-wait add; then I/JAL/JALR through the same path.
    do_reset(OP_R);
    cyc(D_DEF, 1'b0, 1'b0, e_fetch(1'b0), "reset_fetch");
    for (int i = 0; i < 4; i++) begin
      do_reset(op_tab[i]);
      cyc(D_DEF, 1'b1, 1'b0, e_fetch(1'b1), "alu_fetch");
      cyc(D_DEF, 1'b1, 1'b0, e_dec(1'b0), "alu_decode");
      cyc(D_DEF, 1'b1, 1'b0, e_exec(as_tab[i], pcw_tab[i], ps_tab[i], 1'b0), "alu_exec");
      cyc(D_DEF, 1'b1, 1'b0, e_wb(m2r_tab[i]), "alu_wb");
      cyc(D_DEF, 1'b0, 1'b0, e_fetch(1'b0), "alu_next_fetch");
    end

    // Loads with 3 fixed and then random memory wait counts.
    for (int n = 0; n < 4; n++) begin
      int waits;
      waits = (n == 0) ? 3 : $urandom_range(0, 6);
      do_reset(OP_L);
      cyc(D_DEF, 1'b1, 1'b0, e_fetch(1'b1), "lw_fetch");
      cyc(D_DEF, 1'b1, 1'b0, e_dec(1'b0), "lw_decode");
      cyc(D_DEF, 1'b0, 1'b0, e_exec(1'b1, 1'b0, 2'b00, 1'b0), "lw_exec");
      for (int w = 0; w < waits; w++) cyc(D_DEF, 1'b0, 1'b0, e_mem(1'b0, 1'b0), "lw_mem_wait");
      cyc(D_DEF, 1'b1, 1'b0, e_mem(1'b0, 1'b0), "lw_mem_done");
      cyc(D_DEF, 1'b1, 1'b0, e_wb(2'b01), "lw_wb");
      cyc(D_DEF, 1'b0, 1'b0, e_fetch(1'b0), "lw_next_fetch");
    end

    // Branch taken and not taken; mem_ready in non-memory states is ignored.
    for (int t = 0; t < 2; t++) begin
      logic bt;
      bt = (t == 0);
      do_reset(OP_B);
      cyc(D_DEF, 1'b1, 1'b0, e_fetch(1'b1), "beq_fetch");
      cyc(D_DEF, 1'b1, 1'b0, e_dec(1'b0), "beq_decode");
      cyc(D_DEF, 1'b1, bt, e_exec(1'b0, bt, 2'b01, 1'b1), "beq_exec");
      cyc(D_DEF, 1'b0, 1'b0, e_fetch(1'b0), "beq_next_fetch");
    end

    // Zero-wait store.
    do_reset(OP_S);
    cyc(D_DEF, 1'b1, 1'b0, e_fetch(1'b1), "sw_fetch");
    cyc(D_DEF, 1'b0, 1'b0, e_dec(1'b0), "sw_decode");
    cyc(D_DEF, 1'b1, 1'b0, e_exec(1'b1, 1'b0, 2'b00, 1'b0), "sw_exec");
    cyc(D_DEF, 1'b1, 1'b0, e_mem(1'b1, 1'b1), "sw_mem_done");
    cyc(D_DEF, 1'b0, 1'b0, e_fetch(1'b0), "sw_next_fetch");

    // Illegal opcode trapping: sticky for 20 cycles, cleared only by rst.
    do_reset(OP_BAD);
    cyc(D_DEF, 1'b1, 1'b0, e_fetch(1'b1), "ill_fetch");
    cyc(D_DEF, 1'b0, 1'b0, e_dec(1'b0), "ill_decode");
    for (int i = 0; i < 20; i++)
      cyc(D_DEF, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e_trap(2'b01), "ill_trap_hold");
    do_reset(OP_R);
    cyc(D_DEF, 1'b0, 1'b0, e_fetch(1'b0), "ill_after_rst");

    // Illegal opcode retires as NOP.
    do_reset(OP_BAD);
    cyc(D_NOP, 1'b1, 1'b0, e_fetch(1'b1), "nop_fetch");
    cyc(D_NOP, 1'b0, 1'b0, e_dec(1'b1), "nop_decode");
    cyc(D_NOP, 1'b0, 1'b0, e_fetch(1'b0), "nop_next_fetch");

    // Store timeout at MEM_TIMEOUT=4.
    do_reset(OP_S);
    cyc(D_T4, 1'b1, 1'b0, e_fetch(1'b1), "to_fetch");
    cyc(D_T4, 1'b0, 1'b0, e_dec(1'b0), "to_decode");
    cyc(D_T4, 1'b0, 1'b0, e_exec(1'b1, 1'b0, 2'b00, 1'b0), "to_exec");
    for (int w = 0; w < 4; w++) cyc(D_T4, 1'b0, 1'b0, e_mem(1'b1, 1'b0), "to_mem_wait");
    cyc(D_T4, 1'b1, 1'b0, e_trap(2'b10), "to_trap");
    cyc(D_T4, 1'b0, 1'b0, e_trap(2'b10), "to_trap_hold");

    // mem_ready on the 4th wait cycle wins over the timeout.
    do_reset(OP_S);
    cyc(D_T4, 1'b1, 1'b0, e_fetch(1'b1), "edge_fetch");
    cyc(D_T4, 1'b0, 1'b0, e_dec(1'b0), "edge_decode");
    cyc(D_T4, 1'b0, 1'b0, e_exec(1'b1, 1'b0, 2'b00, 1'b0), "edge_exec");
    for (int w = 0; w < 3; w++) cyc(D_T4, 1'b0, 1'b0, e_mem(1'b1, 1'b0), "edge_mem_wait");
    cyc(D_T4, 1'b1, 1'b0, e_mem(1'b1, 1'b1), "edge_mem_done");
    cyc(D_T4, 1'b0, 1'b0, e_fetch(1'b0), "edge_next_fetch");

    // Fetch timeout at MEM_TIMEOUT=4.
    do_reset(OP_R);
    for (int w = 0; w < 4; w++) cyc(D_T4, 1'b0, 1'b0, e_fetch(1'b0), "fto_wait");
    cyc(D_T4, 1'b0, 1'b0, e_trap(2'b10), "fto_trap");

    // rst during a load's memory wait aborts it cleanly.
    do_reset(OP_L);
    cyc(D_DEF, 1'b1, 1'b0, e_fetch(1'b1), "abort_fetch");
    cyc(D_DEF, 1'b0, 1'b0, e_dec(1'b0), "abort_decode");
    cyc(D_DEF, 1'b0, 1'b0, e_exec(1'b1, 1'b0, 2'b00, 1'b0), "abort_exec");
    cyc(D_DEF, 1'b0, 1'b0, e_mem(1'b0, 1'b0), "abort_mem_wait");
    do_reset(OP_L);
    cyc(D_DEF, 1'b0, 1'b0, e_fetch(1'b0), "abort_refetch");
    cyc(D_DEF, 1'b1, 1'b0, e_fetch(1'b1), "abort_refetch_done");
    cyc(D_DEF, 1'b0, 1'b0, e_dec(1'b0), "abort_redecode");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
